// File: rtl/dm_store_buffer.sv
// Posted-write buffer between the byte-lane controller and the single-port data RAM.
// Queues byte-masked stores and drains them when the MEM-stage load leaves the port free.
module dm_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic [3:0]    st_wea,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  output logic          stall,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       wea_q  [DEPTH];

  logic [AW-1:0]    st_word, ld_word;
  logic             st_req, ld_match, push, pop;
  logic [DEPTH-1:0] match_vec;

  // Only the word-address field of the byte addresses is relevant here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[31:AW+2], st_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};

  assign st_word = st_addr[AW+1:2];
  assign ld_word = ld_addr[AW+1:2];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign st_req  = st_valid & (st_wea != 4'b0000);

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match_vec[i] = vld_q[i] & (addr_q[i] == ld_word);
    end
  end

  assign ld_match = ld_valid & (|match_vec);
  assign stall    = ~rst & ((st_req & full) | ld_match);
  assign push     = ~rst & st_req & ~stall;

  // A free load owns the port; otherwise the head entry drains, which also
  // clears a pending load hazard one entry per cycle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    pop       = 1'b0;
    if (!rst) begin
      if (ld_valid && !ld_match) begin
        ram_en   = 1'b1;
        ram_addr = ld_word;
      end else if (!empty) begin
        ram_en    = 1'b1;
        ram_we    = wea_q[rd_q];
        ram_addr  = addr_q[rd_q];
        ram_wdata = data_q[rd_q];
        pop       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      if (push) begin
        addr_q[wr_q] <= st_word;
        data_q[wr_q] <= st_data;
        wea_q[wr_q]  <= st_wea;
        vld_q[wr_q]  <= 1'b1;
        wr_q         <= wr_q + PW'(1);
      end
      if (pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: expected RAM writes are queued as stores are
// issued and compared in order as the buffer drains them.
module tb_dm_store_buffer;

  localparam int unsigned AW = 12;
  localparam logic [31:0] FAR = 32'h0000_0F00;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid, ld_valid;
  logic [31:0]   st_addr, st_data, ld_addr;
  logic [3:0]    st_wea;
  logic          stall, ram_en, empty, full;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    w;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  dm_store_buffer #(.DEPTH(4), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_wea    (st_wea),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .stall     (stall),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                          input bit track);
    wr_t e;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_wea   = w;
    if (track) begin
      e.a = a[AW+1:2];
      e.d = d;
      e.w = w;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 12; i++) begin
      step();
      sample();
      if (empty) break;
    end
    check(tag, empty, 1);
  endtask

  // Scoreboard: every RAM write must be the oldest outstanding issued store.
  always @(negedge clk) begin
    if (rst === 1'b0 && ram_en === 1'b1 && ram_we !== 4'b0000) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0h/%0h expected=none", ram_addr, ram_wdata);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        wr_t o;
        e = exp_q.pop_front();
        o.a = ram_addr;
        o.d = ram_wdata;
        o.w = ram_we;
        check("sb_write", o, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_wea = '0;
    ld_valid = 1'b0; ld_addr = '0;

    // Reset held three cycles, with a full-mask store requested in the last.
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) drive_st(32'h40, 32'h1, 4'hF, 0);
      sample();
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_stall", stall, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_addr", ram_addr, 0);
    end

    // Single store, drained the following cycle.
    step(); rst = 1'b0;
    drive_st(32'h0000_0104, 32'hAABB_CCDD, 4'b1100, 1);
    sample();
    check("single_stall", stall, 0);
    check("single_no_early_wr", ram_en, 0);
    step(); st_valid = 1'b0;
    sample();
    check("single_en", ram_en, 1);
    check("single_we", ram_we, 4'b1100);
    check("single_addr", ram_addr, 12'h041);
    check("single_wdata", ram_wdata, 32'hAABB_CCDD);
    check("single_not_empty", empty, 0);
    step(); sample();
    check("single_empty_after", empty, 1);
    check("single_idle", ram_en, 0);

    // Fill while non-matching loads hold the port.
    ld_valid = 1'b1; ld_addr = FAR;
    for (int i = 0; i < 4; i++) begin
      step();
      drive_st(32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, 1);
      sample();
      check("fill_stall", stall, 0);
      check("fill_load_we", ram_we, 0);
    end
    step();
    drive_st(32'h20, 32'hC0DE_0004, 4'h3, 1);
    sample();
    check("fill_full", full, 1);
    check("fill_stall5", stall, 1);
    check("fill_load_addr", ram_addr, 12'h3C0);
    step(); ld_valid = 1'b0;
    sample();
    check("fill_drain_stall", stall, 1);
    check("fill_drain_we", ram_we, 4'hF);
    step(); sample();
    check("fill_accept_stall", stall, 0);
    check("fill_accept_full", full, 0);
    step(); st_valid = 1'b0;
    wait_empty("fill_drained");

    // Load hazard on the head entry.
    ld_valid = 1'b1; ld_addr = FAR;
    step(); drive_st(32'h200, 32'h1111_1111, 4'hF, 1);
    step(); drive_st(32'h300, 32'h2222_2222, 4'hF, 1);
    step(); st_valid = 1'b0; ld_addr = 32'h202;
    sample();
    check("haz1_stall", stall, 1);
    check("haz1_drain_addr", ram_addr, 12'h080);
    step(); sample();
    check("haz1_release", stall, 0);
    check("haz1_load_en", ram_en, 1);
    check("haz1_load_we", ram_we, 0);
    check("haz1_load_addr", ram_addr, 12'h080);
    step(); ld_valid = 1'b0;
    wait_empty("haz1_drained");

    // Load hazard on the second entry: two drain cycles.
    ld_valid = 1'b1; ld_addr = FAR;
    step(); drive_st(32'h300, 32'h3333_3333, 4'h1, 1);
    step(); drive_st(32'h200, 32'h4444_4444, 4'h8, 1);
    step(); st_valid = 1'b0; ld_addr = 32'h200;
    sample();
    check("haz2_stall_a", stall, 1);
    step(); sample();
    check("haz2_stall_b", stall, 1);
    step(); sample();
    check("haz2_release", stall, 0);
    check("haz2_load_we", ram_we, 0);
    check("haz2_load_addr", ram_addr, 12'h080);
    check("haz2_empty", empty, 1);
    step(); ld_valid = 1'b0;

    // Reset with three pending entries; none of them may reach the RAM.
    ld_valid = 1'b1; ld_addr = FAR;
    for (int i = 0; i < 3; i++) begin
      step(); drive_st(32'h500 + 32'(4 * i), 32'hDEAD_0000 + 32'(i), 4'hF, 0);
    end
    step(); st_valid = 1'b0; ld_valid = 1'b0; rst = 1'b1;
    sample();
    check("midrst_ram_en", ram_en, 0);
    check("midrst_stall", stall, 0);
    step(); rst = 1'b0;
    sample();
    check("midrst_empty", empty, 1);
    check("midrst_idle", ram_en, 0);
    for (int i = 0; i < 4; i++) begin
      step(); sample();
    end

    // Zero-mask store while full never stalls and is never queued.
    ld_valid = 1'b1; ld_addr = FAR;
    for (int i = 0; i < 4; i++) begin
      step(); drive_st(32'h600 + 32'(4 * i), 32'h5A5A_0000 + 32'(i), 4'h6, 1);
    end
    step(); drive_st(32'h700, 32'hFFFF_FFFF, 4'h0, 0);
    sample();
    check("zmask_full", full, 1);
    check("zmask_stall", stall, 0);
    step(); sample();
    check("zmask_still_full", full, 1);
    step(); st_valid = 1'b0; ld_valid = 1'b0;
    wait_empty("zmask_drained");

    step(); sample();
    check("sb_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
